// File: rtl/pipe_pkg.sv
// Shared pipeline bundle widths, field offsets and stage-register state encoding.
package pipe_pkg;

  // Control-field widths
  localparam int unsigned WB_CTRL_W  = 2;
  localparam int unsigned M_CTRL_W   = 2;
  localparam int unsigned EX_CTRL_W  = 4;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // EX/MEM bundle: control fields sit in the low-order bits
  localparam int unsigned EX_MEM_CTRL_W = WB_CTRL_W + M_CTRL_W;
  localparam int unsigned EX_MEM_W      = EX_MEM_CTRL_W + XLEN + XLEN + REG_ADDR_W;
  localparam int unsigned EX_MEM_M_LSB   = 0;
  localparam int unsigned EX_MEM_WB_LSB  = EX_MEM_M_LSB + M_CTRL_W;
  localparam int unsigned EX_MEM_RD_LSB  = EX_MEM_WB_LSB + WB_CTRL_W;
  localparam int unsigned EX_MEM_WD_LSB  = EX_MEM_RD_LSB + REG_ADDR_W;
  localparam int unsigned EX_MEM_ALU_LSB = EX_MEM_WD_LSB + XLEN;

  // ID/EX bundle: WB + M + EX control, two operands, immediate, destination
  localparam int unsigned ID_EX_CTRL_W = WB_CTRL_W + M_CTRL_W + EX_CTRL_W;
  localparam int unsigned ID_EX_W      = ID_EX_CTRL_W + 3 * XLEN + REG_ADDR_W;

  // MEM/WB bundle: WB control, memory data, ALU result, destination
  localparam int unsigned MEM_WB_CTRL_W = WB_CTRL_W;
  localparam int unsigned MEM_WB_W      = MEM_WB_CTRL_W + XLEN + XLEN + REG_ADDR_W;

  // EX/MEM payload; last field is least significant
  typedef struct packed {
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       wd;
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_CTRL_W-1:0]  wb;
    logic [M_CTRL_W-1:0]   m;
  } ex_mem_t;

  // Occupancy of a skid-buffered stage
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
module pipe_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] r_cnt;

  // Count enabled events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, flush, optional
// 2-entry skid buffer, control-field masking of bubbles, bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EX_MEM_W,
  parameter int unsigned CTRL_W = EX_MEM_CTRL_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_main;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_take;

  assign w_in_fire  = valid_i && w_ready;
  assign w_out_fire = w_valid && ready_i;
  // A beat accepted during a flush is consumed but never stored
  assign w_take     = w_in_fire && !flush_i;

  if (SKID != 0) begin : g_skid
    stage_state_e      r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    // Occupancy FSM: main holds the head beat, skid catches one beat of backpressure
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= ST_EMPTY;
        r_main  <= '0;
        r_skid  <= '0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_take) begin
              r_main  <= data_i;
              r_state <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
              if (w_take) r_main <= data_i;
            end else if (w_out_fire) begin
              r_state <= ST_EMPTY;
            end else if (w_in_fire) begin
              if (w_take) r_skid <= data_i;
              r_state <= ST_TWO;
            end
          end
          ST_TWO: begin
            if (w_out_fire) begin
              r_main  <= r_skid;
              r_state <= ST_ONE;
            end
          end
          default: r_state <= ST_EMPTY;
        endcase
        if (flush_i) r_state <= ST_EMPTY;
      end
    end

    assign w_valid = (r_state != ST_EMPTY);
    // Ready comes from registered state only; reset holds it low
    assign w_ready = !rst_i && (r_state != ST_TWO);
    assign w_main  = r_main;
  end else begin : g_single
    logic              r_valid;
    logic [DATA_W-1:0] r_main;

    // Single register: load whenever the slot is empty or being drained
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid <= 1'b0;
        r_main  <= '0;
      end else if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_ready) begin
        r_main  <= data_i;
        r_valid <= valid_i;
      end
    end

    assign w_valid = r_valid;
    assign w_ready = !rst_i && (!r_valid || ready_i);
    assign w_main  = r_main;
  end

  assign valid_o = w_valid;
  assign ready_o = w_ready;
  assign data_o  = {w_main[DATA_W-1:CTRL_W], w_valid ? w_main[CTRL_W-1:0] : CTRL_W'(0)};

  pipe_sat_cnt #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (!w_valid && ready_i),
    .cnt_o (bubble_cnt_o)
  );

endmodule
